// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-requester round-robin arbiter in front of a single-port
// data memory.
//
// Each access takes two cycles: ACCESS (memory port enabled, gnt pulse) then
// DONE (done pulse). DONE arbitrates like IDLE, so a pending request is granted
// back-to-back. The peak rate is one access every 2 cycles.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req0/1, we0/1, addr0/1,       requester side; inputs held stable until gnt
//   wdata0/1
//   gnt0/1, done0/1               one-cycle pulses: access on the port / completion
//   rdata                         last read result, held until the next read completes
//   busy                          high in ACCESS and DONE
//   mem_enable, mem_write,        memory side, every signal straight from a flop
//   mem_read_addr, mem_write_addr,
//   mem_write_data
//   mem_read_data                 combinational read data from the memory

// Per-requester handshake flops. gnt and done are registered here so neither
// pulse can glitch.
module dmem_arbiter_port (
  input  logic clk,
  input  logic rst_n,
  input  logic gnt_set,
  input  logic done_set,
  output logic gnt,
  output logic done
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= 1'b0;
      done <= 1'b0;
    end else begin
      gnt  <= gnt_set;
      done <= done_set;
    end
  end
endmodule

module dmem_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       mem_enable,
  output logic       mem_write,
  output logic [7:0] mem_read_addr,
  output logic [7:0] mem_write_addr,
  output logic [7:0] mem_write_data,
  input  logic [7:0] mem_read_data
);
  localparam int NUM_REQ = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } dmem_req_t;

  logic [1:0]                state;
  logic                      ptr;     // requester that wins the next tie
  logic                      owner;   // requester of the access in flight
  logic                      we_q;

  logic [NUM_REQ-1:0]        req_vec;
  dmem_req_t [NUM_REQ-1:0]   req_in;
  dmem_req_t                 win_req;
  logic                      arb;
  logic                      win;
  logic [NUM_REQ-1:0]        gnt_set, done_set, gnt_vec, done_vec;

  assign req_vec   = {req1, req0};
  assign req_in[0] = {we0, addr0, wdata0};
  assign req_in[1] = {we1, addr1, wdata1};

  // Arbitration is live in IDLE and DONE. With a single request it wins.
  // With both, the pointer decides.
  always_comb begin
    arb     = (state != ST_ACCESS) && (|req_vec);
    win     = (&req_vec) ? ptr : req_vec[1];
    win_req = req_in[win];
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign gnt_set[i]  = arb && (win == 1'(i));
    assign done_set[i] = (state == ST_ACCESS) && (owner == 1'(i));

    dmem_arbiter_port u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .gnt_set  (gnt_set[i]),
      .done_set (done_set[i]),
      .gnt      (gnt_vec[i]),
      .done     (done_vec[i])
    );
  end

  assign gnt0  = gnt_vec[0];
  assign gnt1  = gnt_vec[1];
  assign done0 = done_vec[0];
  assign done1 = done_vec[1];

  // The memory writes combinationally while enabled. Every memory-side output
  // is therefore a flop that is set up on the edge entering ACCESS. Reset
  // clears these flops asynchronously, so it cuts an access off mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ptr            <= 1'b0;
      owner          <= 1'b0;
      we_q           <= 1'b0;
      busy           <= 1'b0;
      mem_enable     <= 1'b0;
      mem_write      <= 1'b0;
      mem_read_addr  <= 8'h00;
      mem_write_addr <= 8'h00;
      mem_write_data <= 8'h00;
      rdata          <= 8'h00;
    end else begin
      case (state)
        ST_ACCESS: begin
          state      <= ST_DONE;
          busy       <= 1'b1;
          mem_enable <= 1'b0;
          mem_write  <= 1'b0;
          if (!we_q) rdata <= mem_read_data;
        end
        default: begin
          // IDLE and DONE share the same arbitration. The unused encoding
          // falls through here as well and recovers like IDLE.
          if (arb) begin
            state          <= ST_ACCESS;
            owner          <= win;
            ptr            <= ~win;
            we_q           <= win_req.we;
            busy           <= 1'b1;
            mem_enable     <= 1'b1;
            mem_write      <= win_req.we;
            mem_read_addr  <= win_req.addr;
            mem_write_addr <= win_req.addr;
            mem_write_data <= win_req.wdata;
          end else begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. The reference model works at the
// transaction level. A grant is possible at any edge that was not itself
// preceded by a grant one edge earlier. Ties go to the round-robin pointer.
// An access completes on the edge after its grant, and at that point a
// shadow memory is read or written.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rq [2];
  logic       wq [2];
  logic [7:0] aq [2];
  logic [7:0] dq [2];
  logic       gnt0, gnt1, done0, done1, busy, mem_enable, mem_write;
  logic [7:0] rdata, mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
    .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write on the edge that closes an enabled
  // write cycle.
  assign mem_read_data = mem[mem_read_addr];
  always @(posedge clk)
    if (rst_n && mem_enable && mem_write) mem[mem_write_addr] <= mem_write_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  int         ptr_m;
  bit         pv;             // an access was granted on the previous edge
  int         pid;
  bit         pwe;
  logic [7:0] paddr, pwdata;
  logic [7:0] e_rdata, e_addr, e_wdata;
  int         g_last;         // winner at the most recent edge, -1 if none
  int         gnt_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0; pv = 0; pid = -1; pwe = 0; paddr = 0; pwdata = 0;
    e_rdata = 8'h00; e_addr = 8'h00; e_wdata = 8'h00; g_last = -1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt",   {gnt1, gnt0}, 0);
    chk("rst_done",  {done1, done0}, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_men",   mem_enable, 0);
    chk("rst_mwr",   mem_write, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_raddr", mem_read_addr, 8'h00);
    chk("rst_waddr", mem_write_addr, 8'h00);
    chk("rst_wdata", mem_write_data, 8'h00);
  endtask

  // One clock: evaluate the model on the inputs present at the edge, then
  // compare every output a little after the edge.
  task automatic step();
    int  g, d;
    bit  gwe;
    @(posedge clk);
    #1;
    g = -1; d = -1; gwe = 0;
    if (pv) begin
      d = pid;
      if (pwe) ref_mem[paddr] = pwdata;
      else     e_rdata = ref_mem[paddr];
    end else if (rq[0] || rq[1]) begin
      g = (rq[0] && rq[1]) ? ptr_m : (rq[1] ? 1 : 0);
      ptr_m  = 1 - g;
      gwe    = wq[g];
      e_addr = aq[g];
      e_wdata = dq[g];
      gnt_log.push_back(g);
    end
    chk("gnt0",  gnt0,  g == 0);
    chk("gnt1",  gnt1,  g == 1);
    chk("done0", done0, d == 0);
    chk("done1", done1, d == 1);
    chk("busy",  busy,  (g >= 0) || (d >= 0));
    chk("men",   mem_enable, g >= 0);
    chk("mwr",   mem_write,  (g >= 0) && gwe);
    chk("raddr", mem_read_addr, e_addr);
    chk("waddr", mem_write_addr, e_addr);
    chk("rdata", rdata, e_rdata);
    if (g >= 0 && gwe) chk("wdata", mem_write_data, e_wdata);
    chk("gnt_onehot",  gnt0 & gnt1, 0);
    chk("done_onehot", done0 & done1, 0);
    chk("mwr_implies_men", mem_write & ~mem_enable, 0);
    pv = (g >= 0); pid = g; pwe = gwe; paddr = e_addr; pwdata = e_wdata;
    g_last = g;
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input logic [7:0] a, input logic [7:0] dd);
    rq[i] = r; wq[i] = w; aq[i] = a; dq[i] = dd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 8'h09;
      ref_mem[i] = 8'h09;
    end
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    model_reset();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from the default memory contents
    set_req(0, 1, 0, 8'h10, 8'h00);
    step();
    chk("single_gnt_c1", gnt0, 1);
    rq[0] = 0;
    step();
    chk("single_done_c2", done0, 1);
    chk("single_rdata", rdata, 8'h09);
    step();

    // req1 writes A5 to 20, then reads it back
    set_req(1, 1, 1, 8'h20, 8'hA5);
    step();
    wq[1] = 0; dq[1] = 8'h00;   // next request: a read of the same address
    step();
    step();
    chk("wr_rd_gnt1", gnt1, 1);
    chk("wr_rd_mwr_low", mem_write, 0);
    rq[1] = 0;
    step();
    chk("wr_rd_done1_rdata", rdata, 8'hA5);
    step();

    // A request raised and dropped between edges is never seen
    @(posedge clk);
    #1 rq[0] = 1;
    #3 rq[0] = 0;
    step();
    chk("dropped_req_no_gnt", gnt0 | gnt1, 0);

    // Contention: both held, alternating grants starting at requester 0
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    set_req(0, 1, 0, 8'h01, 8'h00);
    set_req(1, 1, 0, 8'h02, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("contention_busy", busy, 1);
    end
    chk("contention_cnt", gnt_log.size(), 4);
    for (int k = 0; k < gnt_log.size(); k++) chk("contention_order", gnt_log[k], k % 2);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    step();

    // Back-to-back: req0 alone for three accesses
    gnt_log.delete();
    set_req(0, 1, 0, 8'h03, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b2b_busy", busy, 1);
    end
    chk("b2b_cnt", gnt_log.size(), 3);
    rq[0] = 0;
    step();
    step();

    // Reset in the middle of a write access to 30
    set_req(0, 1, 1, 8'h30, 8'h77);
    step();
    chk("abort_men_before", mem_enable, 1);
    rq[0] = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_men", mem_enable, 0);
    chk("abort_gnt", gnt0, 0);
    chk("abort_rdata", rdata, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("abort_no_done", done0 | done1, 0);
    step();
    set_req(0, 1, 0, 8'h30, 8'h00);
    step();
    rq[0] = 0;
    step();
    chk("abort_mem_untouched", rdata, 8'h09);

    // Randomized traffic over a small address window
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (g_last == i) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
          else
            rq[i] = 0;
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 req0, req1  input  1 each  access request from requester 0 (CPU load/store) and requester 1 (DMA/debug).
REQ-004 we0, we1  input  1 each  1 = write, 0 = read; held stable with req until granted.
REQ-005 addr0, addr1  input  8 each  target address; held stable with req until granted.
REQ-006 wdata0, wdata1  input  8 each  write data; held stable with req until granted.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse; the requester's access is on the memory port this cycle.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse, the cycle after the matching gnt.
REQ-009 rdata  output  8  read result; valid while done pulses after a read, then held until the next read completes.
REQ-010 busy  output  1  high in ACCESS and DONE.
REQ-011 mem_enable, mem_write  output  1 each  memory port enable and write strobe.
REQ-012 mem_read_addr, mem_write_addr  output  8 each  both driven with the same latched address.
REQ-013 mem_write_data  output  8  latched write data.
REQ-014 mem_read_data  input  8  combinational read data from the data memory.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-016 IDLE: if req0 or req1 is high at a rising edge, the arbiter SHALL latch the winner's id, we, addr and wdata, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 Winner: if only one req is high, that requester wins; if both are high, the requester selected by the round-robin pointer wins.
REQ-018 Round-robin pointer: reset value 0; after every grant it SHALL point to the requester that was not granted.
REQ-019 ACCESS lasts exactly one cycle; mem_enable SHALL be 1, mem_write SHALL equal the latched we, and gnt of the owner SHALL be 1.
REQ-020 At the end of ACCESS on a read, rdata SHALL capture mem_read_data; on a write, rdata SHALL be unchanged. The FSM SHALL then go to DONE.
REQ-021 DONE: done of the owner SHALL be 1 and mem_enable SHALL be 0.
REQ-022 DONE arbitrates exactly as IDLE: if a req is pending, go to ACCESS (back-to-back); else go to IDLE.
REQ-023 Peak throughput SHALL be one access per 2 cycles. Latency SHALL be 1 cycle from req sampled to gnt, and 2 cycles to done.
REQ-024 A req still high in the cycle after its done SHALL count as a new request. A req dropped before it is sampled SHALL be ignored.
REQ-025 Each memory-side output SHALL come directly from a flop (glitch-free), because the memory writes combinationally while enabled.
REQ-026 Outside ACCESS: mem_enable=0 and mem_write=0. Address and data outputs SHALL hold their last values.
REQ-027 gnt0/gnt1 SHALL never be high together; done0/done1 SHALL never be high together.

Reset
REQ-028 When rst_n=0, the following SHALL hold asynchronously: state=IDLE, pointer=0, all gnt/done/busy/mem_enable/mem_write=0, and rdata plus all mem address/data outputs=8'h00.
REQ-029 Reset during ACCESS SHALL abort the access immediately. No done SHALL be issued, and the aborted request SHALL not be retained after rst_n rises.

Verification
REQ-030 Single read: after reset, req0=1, we0=0, addr0=8'h10 (memory default 8'h09) -> gnt0 at cycle 1, done0 at cycle 2 with rdata=8'h09.
REQ-031 Write then read: req1 writes 8'hA5 to 8'h20; req1 then reads 8'h20 -> mem_write=1 only in the write's ACCESS cycle; the read's done1 shows rdata=8'hA5.
REQ-032 Contention: req0 and req1 high together and held after reset -> grant order 0,1,0,1 with gnt pulses every 2 cycles; busy stays high throughout.
REQ-033 Back-to-back: req0 held high for 3 accesses with req1 low -> three gnt0 pulses, 2 cycles apart, with no IDLE cycle between them.
REQ-034 Reset abort: rst_n driven low during an ACCESS write of 8'h77 -> mem_enable and gnt fall without a clock edge, no done follows, and rdata=8'h00.
REQ-035 Protocol checks throughout: one-hot gnt and done, mem_write implies mem_enable, and each done follows its gnt by exactly one cycle.
